memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words of storage.
REQ-002 Parameter WAIT_CYCLES, default 2, added wait states per access (legal range 0..15).
REQ-003 Parameter BASE_ADDRESS, default 32'h0000_0000, byte address of word 0.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 req_valid  input  1  datapath presents a request.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_address  input  32  byte address (datapath ALU_result).
REQ-010 req_write_data  input  32  store data (datapath write_data).
REQ-011 req_strobe  input  4  byte enables for stores; bit i enables byte lane i (bits 8i+7:8i).
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  datapath consumes the response.
REQ-014 rsp_read_data  output  32  load data (datapath read_data); 0 for stores and errors.
REQ-015 rsp_error  output  1  misaligned or out-of-range access.

Function
REQ-016 The block SHALL implement the states IDLE, WAIT and RESPOND.
REQ-017 req_ready SHALL be 1 only in IDLE with reset high.
REQ-018 A request SHALL be accepted on an edge where req_valid=1 and req_ready=1; address, data, strobe and direction are latched on that edge.
REQ-019 On acceptance, the next state SHALL be WAIT when WAIT_CYCLES>0, loading a wait counter with WAIT_CYCLES; otherwise it SHALL be RESPOND.
REQ-020 WAIT SHALL decrement the counter each cycle and move to RESPOND on the edge where the counter equals 1.
REQ-021 rsp_valid SHALL first be high WAIT_CYCLES+1 cycles after the acceptance edge (W=0: the cycle immediately after acceptance).
REQ-022 The memory access (store commit or load capture) SHALL occur on the edge that enters RESPOND.
REQ-023 Word index SHALL be (req_address-BASE_ADDRESS)>>2, computed with 32-bit unsigned wrap.
REQ-024 An access SHALL be an error when req_address[1:0]!=0 or word index>=DEPTH.
REQ-025 An error access SHALL NOT modify storage and SHALL return rsp_read_data=0 and rsp_error=1.
REQ-026 A store SHALL update only the strobed byte lanes.
REQ-027 A store with req_strobe=0 SHALL be a legal no-op that still produces a response.
REQ-028 A load SHALL ignore req_strobe and return the full word.
REQ-029 In RESPOND, rsp_valid, rsp_read_data and rsp_error SHALL be held stable until an edge with rsp_ready=1, after which the state SHALL be IDLE.
REQ-030 rsp_ready asserted outside RESPOND SHALL be ignored.
REQ-031 rsp_read_data and rsp_error SHALL be 0 whenever rsp_valid=0.
REQ-032 Back-to-back operation: a new request SHALL be accepted no earlier than the cycle after the response handshake; the minimum period is WAIT_CYCLES+2 cycles.

Reset
REQ-033 With reset=0 on an edge, the state SHALL become IDLE, the counter 0, rsp_valid 0, rsp_error 0, rsp_read_data 0 and req_ready 0.
REQ-034 Reset asserted before the access edge SHALL abandon the pending request; a pending store SHALL NOT be committed.
REQ-035 Reset SHALL NOT clear storage contents.

Structure
REQ-036 State encodings (IDLE=2'd0, WAIT=2'd1, RESPOND=2'd2) and the strobe width SHALL live in the shared CPU constants package or include file.
REQ-037 Storage SHALL be one sub-module, byte_ram: DEPTH words, 4 byte-lane write enables, synchronous write, asynchronous read.

Verification
REQ-038 Defaults: store 0xDEADBEEF to 0x10 with strobe 4'hF, then load 0x10 -> rsp_read_data=0xDEADBEEF, rsp_error=0, rsp_valid 3 cycles after each acceptance.
REQ-039 Byte store 0x000000AA to 0x10 with strobe 4'b0001 over 0xDEADBEEF, then load -> 0xDEADBEAA.
REQ-040 Load from 0x13 (misaligned) and from 0x400 (DEPTH=256) -> rsp_error=1, rsp_read_data=0; a store to 0x400 leaves word 0 unchanged.
REQ-041 Hold rsp_ready=0 for 5 cycles in RESPOND -> outputs stable and req_ready=0 throughout; handshake, then req_ready=1 the next cycle.
REQ-042 WAIT_CYCLES=0 with back-to-back requests -> response the cycle after acceptance, accepts every 2 cycles.
REQ-043 Store 0x12345678 to 0x20 with reset pulsed low during WAIT -> outputs cleared, subsequent load of 0x20 returns the prior value.

Source files
------------

// File: rtl/memory_responder_pkg.sv
// Shared constants for the memory responder: FSM encodings, bus widths and
// the byte-address to word-index helper.
package memory_responder_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RESPOND = 2'd2;

    // Word index relative to the base, with 32-bit unsigned wrap so that
    // addresses below the base land far out of range instead of negative.
    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        logic [31:0] w_off;
        w_off = addr - base;
        return w_off >> 2;
    endfunction

endpackage

// File: rtl/memory_responder_byte_ram.sv
// Word storage with per-byte-lane write enables: synchronous write,
// asynchronous read on the same address port.
module byte_ram
    import memory_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic [STRB_W-1:0] i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Each enabled byte lane is written independently; contents survive reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < STRB_W; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/memory_responder.sv
// Single-outstanding load/store responder with a fixed number of wait states.
// IDLE accepts a request, WAIT counts down the wait states, and the edge that
// enters RESPOND performs the access and registers the response, which is
// held until the datapath handshakes it.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int          DEPTH        = 256,
    parameter int          WAIT_CYCLES  = 2,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_address,
    input  logic [31:0]       req_write_data,
    input  logic [STRB_W-1:0] req_strobe,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_read_data,
    output logic              rsp_error
);

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_write;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [STRB_W-1:0] r_strobe;
    logic              r_rsp_valid;
    logic              r_rsp_error;
    logic [31:0]       r_rsp_data;

    logic              w_accept;
    logic              w_access;
    logic              w_live;
    logic              w_acc_write;
    logic [31:0]       w_acc_addr;
    logic [31:0]       w_acc_wdata;
    logic [STRB_W-1:0] w_acc_strobe;
    logic [31:0]       w_index;
    logic              w_err;
    logic [STRB_W-1:0] w_we;
    logic [31:0]       w_rdata;

    assign req_ready = reset & (r_state == ST_IDLE);
    assign w_accept  = req_valid & req_ready;

    // With zero wait states the access happens on the accept edge itself, so
    // the operands come straight from the request rather than the latches.
    assign w_live       = (r_state == ST_IDLE);
    assign w_acc_write  = w_live ? req_write      : r_write;
    assign w_acc_addr   = w_live ? req_address    : r_addr;
    assign w_acc_wdata  = w_live ? req_write_data : r_wdata;
    assign w_acc_strobe = w_live ? req_strobe     : r_strobe;

    assign w_access = reset & (((r_state == ST_WAIT) && (r_cnt == 4'd1)) ||
                               ((WAIT_CYCLES == 0) && w_accept));

    assign w_index = word_index(w_acc_addr, BASE_ADDRESS);
    assign w_err   = (|w_acc_addr[1:0]) | (w_index >= 32'(DEPTH));
    assign w_we    = (w_access & w_acc_write & ~w_err) ? w_acc_strobe : '0;

    byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock   (clock),
        .i_we    (w_we),
        .i_addr  (w_index[AW-1:0]),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_rdata)
    );

    // Request/response FSM; the response registers load on the access edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_strobe    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_data  <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write  <= req_write;
                        r_addr   <= req_address;
                        r_wdata  <= req_write_data;
                        r_strobe <= req_strobe;
                        if (WAIT_CYCLES > 0) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= WAIT_INIT;
                        end else begin
                            r_state <= ST_RESPOND;
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_error <= 1'b0;
                        r_rsp_data  <= 32'd0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_access) begin
                r_rsp_valid <= 1'b1;
                r_rsp_error <= w_err;
                r_rsp_data  <= (w_err | w_acc_write) ? 32'd0 : w_rdata;
            end
        end
    end

    assign rsp_valid     = r_rsp_valid;
    assign rsp_error     = r_rsp_error;
    assign rsp_read_data = r_rsp_data;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: directed literal checks, a zero-wait instance
// for back-to-back throughput, and a randomized run compared every cycle
// against a transaction-level model.
module tb_memory_responder;

    localparam int W     = 2;
    localparam int DEPTH = 256;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_address = 32'd0, req_write_data = 32'd0;
    logic [3:0]  req_strobe = 4'd0;
    logic        req_ready, rsp_valid, rsp_error;
    logic [31:0] rsp_read_data;

    logic        w0_req_valid = 1'b0, w0_req_write = 1'b0, w0_rsp_ready = 1'b0;
    logic [31:0] w0_req_address = 32'd0, w0_req_write_data = 32'd0;
    logic [3:0]  w0_req_strobe = 4'd0;
    logic        w0_req_ready, w0_rsp_valid, w0_rsp_error;
    logic [31:0] w0_rsp_read_data;

    always #5 clock = ~clock;

    memory_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W), .BASE_ADDRESS(32'h0)) u_dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_address(req_address), .req_write_data(req_write_data),
        .req_strobe(req_strobe), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_read_data(rsp_read_data), .rsp_error(rsp_error)
    );

    memory_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .BASE_ADDRESS(32'h0)) u_w0 (
        .clock(clock), .reset(reset), .req_valid(w0_req_valid), .req_ready(w0_req_ready),
        .req_write(w0_req_write), .req_address(w0_req_address),
        .req_write_data(w0_req_write_data), .req_strobe(w0_req_strobe),
        .rsp_valid(w0_rsp_valid), .rsp_ready(w0_rsp_ready),
        .rsp_read_data(w0_rsp_read_data), .rsp_error(w0_rsp_error)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding request, response visible W
    // edges after the accept edge, access performed at that point.
    int          cyc = 0;
    bit          m_busy = 1'b0;
    int          m_acc = 0;
    logic        m_wr = 1'b0;
    logic [31:0] m_addr = 32'd0, m_wd = 32'd0;
    logic [3:0]  m_st = 4'd0;
    logic [31:0] m_rd = 32'd0;
    logic        m_er = 1'b0;
    logic [31:0] m_mem [DEPTH];

    always @(posedge clock) begin : model
        logic [31:0] idx;
        cyc++;
        if (!reset) begin
            m_busy = 1'b0;
        end else begin
            if (m_busy) begin
                if (cyc > m_acc + W && rsp_ready) m_busy = 1'b0;
            end else if (req_valid) begin
                m_busy = 1'b1;
                m_acc  = cyc;
                m_wr   = req_write;
                m_addr = req_address;
                m_wd   = req_write_data;
                m_st   = req_strobe;
            end
            if (m_busy && cyc == m_acc + W) begin
                idx = (m_addr - 32'h0) / 4;
                if (m_addr % 4 != 0 || idx >= DEPTH) begin
                    m_rd = 32'd0;
                    m_er = 1'b1;
                end else if (m_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (m_st[b]) m_mem[idx][8*b +: 8] = m_wd[8*b +: 8];
                    m_rd = 32'd0;
                    m_er = 1'b0;
                end else begin
                    m_rd = m_mem[idx];
                    m_er = 1'b0;
                end
            end
        end
    end

    always @(negedge clock) begin : compare
        logic ev;
        if (chk_en) begin
            ev = m_busy && (cyc >= m_acc + W);
            chk("rsp_valid", 32'(rsp_valid), 32'(ev));
            chk("rsp_read_data", rsp_read_data, ev ? m_rd : 32'd0);
            chk("rsp_error", 32'(rsp_error), ev ? 32'(m_er) : 32'd0);
            chk("req_ready", 32'(req_ready), 32'(reset && !m_busy));
        end
    end

    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int hold,
                          input logic [31:0] exp_rd, input logic exp_er);
        int lat;
        req_write = wr; req_address = a; req_write_data = d; req_strobe = s;
        rsp_ready = 1'b0; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 50) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(W + 1));
        chk("rd_data", rsp_read_data, exp_rd);
        chk("rd_err", 32'(rsp_error), 32'(exp_er));
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", rsp_read_data, exp_rd);
            chk("hold_err", 32'(rsp_error), 32'(exp_er));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        chk("post_hs_valid", 32'(rsp_valid), 32'd0);
        chk("post_hs_ready", 32'(req_ready), 32'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        int          k;
        logic [31:0] a;
        k = int'($urandom_range(0, 9));
        a = 32'($urandom_range(0, 31)) << 2;
        if (k == 0)      a = a | 32'($urandom_range(1, 3));
        else if (k == 1) a = 32'h400 + (32'($urandom_range(0, 255)) << 2);
        else if (k == 2) a = 32'hFFFF_FFFC;
        return a;
    endfunction

    logic [31:0] w0_exp_d [4] = '{32'd0, 32'hCAFE_F00D, 32'd0, 32'hCAFE_F00D};
    logic        w0_exp_e [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        w0_wr    [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] w0_ad    [4] = '{32'h10, 32'h10, 32'h13, 32'h10};

    initial begin
        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_data", rsp_read_data, 32'd0);
        chk("reset_err", 32'(rsp_error), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk_en = 1'b1;
        reset  = 1'b1;
        @(posedge clock); #1;
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        // Full-word store/load, byte-lane merge, errors, stall, strobe-0 no-op.
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 32'd0, 1'b0);
        do_req(1'b0, 32'h10, 32'd0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 0, 32'd0, 1'b0);
        do_req(1'b0, 32'h10, 32'd0, 4'hF, 0, 32'hDEAD_BEAA, 1'b0);
        chk("model_pin_word4", m_mem[4], 32'hDEAD_BEAA);
        do_req(1'b1, 32'h0, 32'h0A0B_0C0D, 4'hF, 0, 32'd0, 1'b0);
        do_req(1'b0, 32'h13, 32'd0, 4'hF, 0, 32'd0, 1'b1);
        do_req(1'b0, 32'h400, 32'd0, 4'hF, 0, 32'd0, 1'b1);
        do_req(1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 0, 32'd0, 1'b1);
        do_req(1'b0, 32'h0, 32'd0, 4'h0, 0, 32'h0A0B_0C0D, 1'b0);
        chk("model_pin_word0", m_mem[0], 32'h0A0B_0C0D);
        do_req(1'b0, 32'h10, 32'd0, 4'hF, 5, 32'hDEAD_BEAA, 1'b0);
        do_req(1'b1, 32'h10, 32'h5555_5555, 4'h0, 0, 32'd0, 1'b0);
        do_req(1'b0, 32'h10, 32'd0, 4'hF, 0, 32'hDEAD_BEAA, 1'b0);

        // Reset pulse during WAIT abandons the pending store.
        do_req(1'b1, 32'h20, 32'h1111_1111, 4'hF, 0, 32'd0, 1'b0);
        req_write = 1'b1; req_address = 32'h20; req_write_data = 32'h1234_5678;
        req_strobe = 4'hF; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        reset     = 1'b0;
        @(posedge clock); #1;
        chk("rst_wait_valid", 32'(rsp_valid), 32'd0);
        chk("rst_wait_data", rsp_read_data, 32'd0);
        chk("rst_wait_err", 32'(rsp_error), 32'd0);
        chk("rst_wait_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_no_late_rsp", 32'(rsp_valid), 32'd0);
        do_req(1'b0, 32'h20, 32'd0, 4'hF, 0, 32'h1111_1111, 1'b0);

        // Zero-wait instance: back-to-back, one response every two cycles.
        w0_rsp_ready = 1'b1;
        w0_req_write = w0_wr[0]; w0_req_address = w0_ad[0];
        w0_req_write_data = 32'hCAFE_F00D; w0_req_strobe = 4'hF; w0_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            chk("w0_rsp_valid", 32'(w0_rsp_valid), 32'd1);
            chk("w0_rsp_data", w0_rsp_read_data, w0_exp_d[i]);
            chk("w0_rsp_err", 32'(w0_rsp_error), 32'(w0_exp_e[i]));
            chk("w0_busy_ready", 32'(w0_req_ready), 32'd0);
            if (i < 3) begin
                w0_req_write = w0_wr[i+1];
                w0_req_address = w0_ad[i+1];
            end else begin
                w0_req_valid = 1'b0;
            end
            @(posedge clock); #1;
            chk("w0_gap_valid", 32'(w0_rsp_valid), 32'd0);
            chk("w0_gap_ready", 32'(w0_req_ready), 32'd1);
        end
        w0_rsp_ready = 1'b0;

        // Fill the random window so every load returns known data.
        for (int i = 0; i < 32; i++)
            do_req(1'b1, 32'(i) << 2, $urandom, 4'hF, 0, 32'd0, 1'b0);

        // Randomized traffic, resets and back-pressure; compare process checks.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock); #1;
            reset          = ($urandom_range(0, 59) != 0);
            req_valid      = ($urandom_range(0, 2) != 0);
            req_write      = 1'($urandom_range(0, 1));
            req_address    = rand_addr();
            req_write_data = $urandom;
            req_strobe     = 4'($urandom_range(0, 15));
            rsp_ready      = ($urandom_range(0, 2) != 0);
        end
        @(posedge clock); #1;
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
